// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_if
// Description : Signal bundle between a local command source, the APB
//               initiator and the APB peripheral side.
//               Local side : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata
//                            and rsp_valid/rsp_rdata/rsp_err/rsp_timeout.
//               APB side   : PSELx/PENABLE/PWRITE/PADDR/PWDATA out,
//                            PREADY/PRDATA/PSLVERR in.
//               modport master : view taken by the initiator (apb_master).
//               modport slave  : view taken by whatever sits around it
//                                (command source + peripheral).
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // local command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // local response channel
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB bus
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PREADY, PRDATA, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PREADY, PRDATA, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : APB initiator. Converts single-beat local read/write
//               commands into APB SETUP/ACCESS transfers and returns exactly
//               one response per accepted command.
//   Ports     : PCLK    - clock, all logic on the rising edge
//               PRESET  - synchronous active-high reset
//               bus     - apb_master_if.master (command, response, APB bus)
//   Params    : ADDR_WIDTH, DATA_WIDTH, TIMEOUT_CYCLES (1..255)
//   Options   : APB_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that
//               sees PREADY low for TIMEOUT_CYCLES cycles is aborted and
//               answered with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//               When undefined, ACCESS waits indefinitely and rsp_timeout
//               is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        PCLK,
    input  wire logic        PRESET,
    apb_master_if.master     bus
);

    // ------------------------------------------------------------------
    // Parameter sanity (elaboration time only)
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_abort;

    // A new command can be taken while idle, or on the very edge the current
    // transfer completes, which gives gap-free SETUP/ACCESS pairs.
    assign w_cmd_ready = (r_state == c_ST_IDLE) ||
                         ((r_state == c_ST_ACCESS) && bus.PREADY);
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_complete  = (r_state == c_ST_ACCESS) && bus.PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Wait-state watchdog. The counter holds the number of PREADY-low
    // ACCESS cycles already seen, so the abort fires on the edge that ends
    // the TIMEOUT_CYCLES-th such cycle. PREADY high on that same cycle is a
    // normal completion because w_abort requires PREADY low.
    // ------------------------------------------------------------------
    localparam logic [7:0] c_WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0]            r_wdog;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wdog <= 8'd0;
        end else if (r_state == c_ST_SETUP) begin
            // every ACCESS phase is entered from SETUP
            r_wdog <= 8'd0;
        end else if ((r_state == c_ST_ACCESS) && !bus.PREADY) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    assign w_abort = (r_state == c_ST_ACCESS) && !bus.PREADY &&
                     (r_wdog == c_WDOG_LAST);
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                w_state_nxt = c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                if (w_complete) begin
                    w_state_nxt = w_accept ? c_ST_SETUP : c_ST_IDLE;
                end else if (w_abort) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // APB outputs. PSELx/PENABLE are registered copies of the next state so
    // they line up with the state register without any output decode.
    // Address/direction/data are loaded only on acceptance, so they stay
    // stable through SETUP and ACCESS and hold afterwards in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_psel    <= (w_state_nxt != c_ST_IDLE);
            r_penable <= (w_state_nxt == c_ST_ACCESS);
            if (w_accept) begin
                r_pwrite <= bus.cmd_write;
                r_paddr  <= bus.cmd_addr;
                r_pwdata <= bus.cmd_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response outputs. rsp_valid is a single-cycle pulse; the payload
    // holds until the next completion or abort. r_pwrite still describes
    // the finishing transfer on the completion edge even if a new command
    // is accepted on that edge (non-blocking update).
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= w_complete || w_abort;
            if (w_complete) begin
                r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                r_rsp_err     <= bus.PSLVERR;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Port mapping
    // ------------------------------------------------------------------
    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.PSELx       = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire
